lu_serial_driver: RTL and testbench
===================================

// Module: lu_serial_driver
// PURPOSE
//  Initiator side of the 1-bit OR/NOR logic-unit interface (a, b, select -> s).
//  Accepts one WIDTH-bit operand pair plus opcode on a valid/ready request port.
//  Drives the 1-bit LU bit-serially, LSB first, one bit per clock.
//  Reassembles the returned bits into a WIDTH-bit result on a valid/ready response port.
// PARAMETERS
//  WIDTH   8   operand/result width in bits; legal range 2..32
// PORTS
//  clk        in   1      single clock; all state updates on rising edge
//  reset      in   1      synchronous, active-high reset
//  in_valid   in   1      request valid
//  in_ready   out  1      request ready; 1 only in IDLE
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B
//  in_sel     in   1      opcode: 0 = OR, 1 = NOR
//  lu_a       out  1      bit to LU input a
//  lu_b       out  1      bit to LU input b
//  lu_sel     out  1      LU select
//  lu_s       in   1      LU result bit; combinational, same-cycle
//  out_valid  out  1      result valid
//  out_ready  in   1      result accepted
//  out_s      out  WIDTH  assembled result
//  out_sel    out  1      opcode of the returned result
//  busy       out  1      1 in RUN or DONE
// BEHAVIOUR
//  - Reset (clk edge with reset=1):
//      state = IDLE; counter, operand and result registers cleared.
//      Outputs after reset: out_valid=0, out_s=0, out_sel=0, lu_a/lu_b/lu_sel=0, busy=0, in_ready=1.
//  - Reset wins over every other event, including mid-RUN and in DONE.
//    An in-flight operation is discarded with no output.
//  - FSM, 3 states:
//    IDLE: in_ready=1.
//      On edge with in_valid=1: capture in_a, in_b, in_sel; cnt=0; go to RUN.
//    RUN: lu_a=a_q[0], lu_b=b_q[0], lu_sel=sel_q.
//      Each edge: res_q = {lu_s, res_q[WIDTH-1:1]}; a_q>>=1; b_q>>=1; cnt++.
//      On the edge where cnt==WIDTH-1: go to DONE.
//    DONE: out_valid=1; out_s=res_q and out_sel=sel_q, held stable.
//      On edge with out_ready=1: go to IDLE.
//  - lu_a, lu_b and lu_sel are 0 outside RUN.
//  - in_valid is ignored outside IDLE; no request is lost because in_ready=0 there.
//  - Latency: out_valid rises WIDTH cycles after the accepting edge.
//  - Throughput: one operation per WIDTH+2 cycles with out_ready tied to 1.
//  - Backpressure in DONE is unbounded; out_s is held until out_ready=1.
//  - Counter width: $clog2(WIDTH). No wrap occurs, because the count stops at WIDTH-1.
//  - in_ready, out_valid and busy are decoded from state (no combinational input->output paths).
//    Exceptions: lu_s -> res_q is registered; lu outputs are decoded from registers.
// STRUCTURE
//  - Shared include lu_defs.vh holds:
//      LU_OP_OR=1'b0, LU_OP_NOR=1'b1;
//      state encodings S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2 (2'd3 -> IDLE).
//  - Single module: FSM, counter and three shift registers; no sub-module required.
//  - The bench provides the 1-bit OR/NOR cell on the lu_* port.
// TESTING (WIDTH=8; bench ties lu_* to a 1-bit OR/NOR cell: s = sel ? ~(a|b) : (a|b))
//  1 Reset: hold reset 2 cycles ->
//      out_valid=0, out_s=0, busy=0, in_ready=1, lu_a=lu_b=lu_sel=0.
//  2 OR: a=8'hA5, b=8'h0F, sel=0, out_ready=1 ->
//      out_valid rises 8 cycles after accept; out_s=8'hAF, out_sel=0.
//  3 NOR: a=8'hA5, b=8'h0F, sel=1 ->
//      out_s=8'h50, out_sel=1; lu_sel=1 for exactly 8 cycles.
//  4 Backpressure: out_ready=0 for 5 cycles in DONE, with new in_valid pulses ->
//      out_s stable; in_ready=0; second request not captured.
//  5 Mid-op reset: reset at the 4th RUN cycle ->
//      IDLE next cycle, no out_valid; next op a=8'hFF, b=8'h00, sel=1 -> out_s=8'h00.
//  6 Back-to-back: in_valid and out_ready held at 1 with ops OR(8'h00,8'h00) then NOR(8'h00,8'h00) ->
//      results 8'h00 then 8'hFF; accepts spaced 10 cycles apart.

Source files
------------

// File: rtl/lu_serial_driver_pkg.sv
// rtl/lu_serial_driver_pkg.sv - shared opcode and FSM state definitions for the serial LU driver
package lu_serial_driver_pkg;

  localparam logic LU_OP_OR  = 1'b0;
  localparam logic LU_OP_NOR = 1'b1;

  // Encoding 2'd3 is unreachable and recovers to S_IDLE.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } lu_state_t;

endpackage

// File: rtl/lu_serial_driver.sv
// rtl/lu_serial_driver.sv - bit-serial initiator for the 1-bit OR/NOR logic unit
module lu_serial_driver
  import lu_serial_driver_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sel,
  output logic             lu_a,
  output logic             lu_b,
  output logic             lu_sel,
  input  logic             lu_s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_sel,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  lu_state_t        state, state_n;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic             sel_q;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Operands shift right so the LU always sees bit 0; results enter at the MSB.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      sel_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_q   <= in_a;
            b_q   <= in_b;
            sel_q <= in_sel;
            cnt   <= '0;
          end
        end
        S_RUN: begin
          res_q <= {lu_s, res_q[WIDTH-1:1]};
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          if (cnt != CNT_LAST) cnt <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    lu_a      = 1'b0;
    lu_b      = 1'b0;
    lu_sel    = 1'b0;
    out_s     = '0;
    out_sel   = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_n = S_RUN;
      end
      S_RUN: begin
        busy   = 1'b1;
        lu_a   = a_q[0];
        lu_b   = b_q[0];
        lu_sel = sel_q;
        if (cnt == CNT_LAST) state_n = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_s     = res_q;
        out_sel   = sel_q;
        if (out_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_lu_serial_driver.sv
// tb/tb_lu_serial_driver.sv - self-checking bench for lu_serial_driver with a 1-bit OR/NOR cell model
module tb_lu_serial_driver;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready, in_sel;
  logic [W-1:0] in_a, in_b;
  logic         lu_a, lu_b, lu_sel, lu_s;
  logic         out_valid, out_ready, out_sel, busy;
  logic [W-1:0] out_s;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int sel_hi = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (lu_sel) sel_hi++;

  assign lu_s = lu_sel ? ~(lu_a | lu_b) : (lu_a | lu_b);

  lu_serial_driver #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sel(in_sel),
    .lu_a(lu_a), .lu_b(lu_b), .lu_sel(lu_sel), .lu_s(lu_s),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_s(out_s), .out_sel(out_sel), .busy(busy)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sel;
    logic [W-1:0] exp_s;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation from IDLE; holds out_ready low for bp cycles once out_valid is up.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sel,
                       input int bp, output logic [W-1:0] res, output logic rsel, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin tick(); guard++; end
    in_a = a; in_b = b; in_sel = sel; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_a = $urandom; in_b = $urandom; in_sel = $urandom;
    lat = 0;
    while (!out_valid && lat < 100) begin tick(); lat++; end
    repeat (bp) tick();
    res = out_s;
    rsel = out_sel;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  logic [W-1:0] r, held;
  logic         rs;
  int           lat;
  int           acc_t[$];
  logic [W-1:0] res_q[$];
  logic [W-1:0] ra, rb, exp_r;
  logic         rsl;
  int           saw_valid;

  initial begin
    vecs[0] = '{a: 8'hA5, b: 8'h0F, sel: 1'b0, exp_s: 8'hAF};
    vecs[1] = '{a: 8'hA5, b: 8'h0F, sel: 1'b1, exp_s: 8'h50};
    vecs[2] = '{a: 8'hFF, b: 8'h00, sel: 1'b1, exp_s: 8'h00};
    vecs[3] = '{a: 8'h00, b: 8'h00, sel: 1'b0, exp_s: 8'h00};
    vecs[4] = '{a: 8'h00, b: 8'h00, sel: 1'b1, exp_s: 8'hFF};
    vecs[5] = '{a: 8'h81, b: 8'h18, sel: 1'b0, exp_s: 8'h99};

    reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_sel = 1'b0; out_ready = 1'b0;
    tick(); tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_out_s", out_s, 0);
    check("rst_out_sel", out_sel, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_lu", {lu_a, lu_b, lu_sel}, 0);
    reset = 1'b0;
    tick();

    foreach (vecs[i]) begin
      sel_hi = 0;
      do_op(vecs[i].a, vecs[i].b, vecs[i].sel, 0, r, rs, lat);
      check($sformatf("vec%0d_out_s", i), r, vecs[i].exp_s);
      check($sformatf("vec%0d_out_sel", i), rs, vecs[i].sel);
      check($sformatf("vec%0d_latency", i), lat, W);
      check($sformatf("vec%0d_lu_sel_cycles", i), sel_hi, vecs[i].sel ? W : 0);
    end

    // Backpressure with competing requests while the result is held.
    in_a = 8'h3C; in_b = 8'h41; in_sel = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin tick(); lat++; end
    check("bp_latency", lat, W);
    held = out_s;
    check("bp_result", held, 8'h7D);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_a = $urandom; in_b = $urandom; in_sel = $urandom;
      tick();
      check($sformatf("bp_hold_s_%0d", k), out_s, 8'h7D);
      check($sformatf("bp_in_ready_%0d", k), in_ready, 0);
      check($sformatf("bp_valid_%0d", k), out_valid, 1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_idle_in_ready", in_ready, 1);
    check("bp_not_captured", busy, 0);

    // Reset at the 4th RUN cycle discards the operation.
    in_a = 8'hAA; in_b = 8'h55; in_sel = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    check("mid_busy_before", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_in_ready", in_ready, 1);
    check("mid_busy", busy, 0);
    check("mid_lu", {lu_a, lu_b, lu_sel}, 0);
    saw_valid = 0;
    repeat (12) begin tick(); if (out_valid) saw_valid++; end
    check("mid_no_out_valid", saw_valid, 0);
    do_op(8'hFF, 8'h00, 1'b1, 0, r, rs, lat);
    check("mid_next_op", r, 8'h00);

    // Back-to-back with in_valid and out_ready held high.
    in_a = 8'h00; in_b = 8'h00; in_sel = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 60 && res_q.size() < 2; k++) begin
      @(negedge clk);
      if (in_ready && in_valid) acc_t.push_back(cyc);
      if (out_valid && out_ready) res_q.push_back(out_s);
      tick();
      if (acc_t.size() == 1) in_sel = 1'b1;
      if (acc_t.size() == 2) in_valid = 1'b0;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("b2b_accepts", acc_t.size(), 2);
    check("b2b_results", res_q.size(), 2);
    if (acc_t.size() == 2) check("b2b_spacing", acc_t[1] - acc_t[0], W + 2);
    if (res_q.size() == 2) begin
      check("b2b_res0", res_q[0], 8'h00);
      check("b2b_res1", res_q[1], 8'hFF);
    end
    tick(); tick();

    // Randomized operations against the bitwise OR/NOR reference.
    for (int k = 0; k < 20; k++) begin
      ra = $urandom; rb = $urandom; rsl = $urandom;
      exp_r = rsl ? ~(ra | rb) : (ra | rb);
      do_op(ra, rb, rsl, $urandom_range(0, 3), r, rs, lat);
      check($sformatf("rnd%0d_out_s", k), r, exp_r);
      check($sformatf("rnd%0d_out_sel", k), rs, rsl);
      check($sformatf("rnd%0d_latency", k), lat, W);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
